upg_loader: RTL

Byte-stream program loader for the UART programming (UPG) path. Consumes bytes from the UART receiver and parses a framed image into 32-bit words. Drives the `upg_wen`/`upg_addr`/`upg_data`/`upg_done` bus that feeds instruction and data memory while the CPU is held in programming mode. Asserting `upg_done_o` hands memory back to the CPU, which then runs the loaded image.

---
 rtl/upg_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/upg_loader.sv
// Purpose : UART programming loader; parses TGT, CNT_LO, CNT_HI, N little-endian words into memory writes.
// Latency : upg_wen_o 1 cycle after the b3 strobe; done 2 cycles after the last data byte (1 after CNT_HI when N=0).
// Backpress: none; consumes one byte per rx_valid_i, back-to-back legal; bytes after DONE/ERR are dropped.
//
// Ports: upg_clk_i/upg_rst_i (async active-high), rx_data_i/rx_valid_i byte strobe in;
//        upg_tgt_o (0=imem, 1=dmem), upg_wen_o/upg_addr_o/upg_data_o write bus,
//        upg_done_o / upg_err_o sticky status until reset.
// Option : define UPG_CHECKSUM_EN to expect a trailing XOR checksum byte over CNT_LO, CNT_HI and data.
module upg_loader #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              upg_tgt_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_addr_o,
    output logic [31:0]       upg_data_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);

    localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

`ifdef UPG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_CNT0, S_CNT1, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    // S_FIN is a one-cycle drain so the final write pulse lands before done hands memory back.
    typedef enum logic [2:0] {S_IDLE, S_CNT0, S_CNT1, S_DATA, S_FIN, S_DONE, S_ERR} state_t;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      cnt_lo_q;
    logic [15:0]     word_cnt_q;
    logic [15:0]     word_idx_q;
    logic [1:0]      byte_idx_q;
    logic [23:0]     word_buf_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            counting;
    logic            timeout_hit;
    logic            last_word;
    logic            in_range;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]      chk_q;
`endif

    assign counting = (state_q == S_CNT0) || (state_q == S_CNT1) || (state_q == S_DATA)
`ifdef UPG_CHECKSUM_EN
                      || (state_q == S_CHK)
`endif
                      ;
    assign timeout_hit = counting && (to_cnt_q == TO_LAST);
    assign last_word   = ({1'b0, word_idx_q} + 17'd1) == {1'b0, word_cnt_q};
    // Words beyond the memory depth are consumed but never written (no address wrap).
    assign in_range    = ((32'(word_idx_q) >> ADDR_W) == 32'd0);

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte in the same cycle as the timeout terminal count takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    state_d = (rx_data_i[7:1] == 7'd0) ? S_CNT0 : S_ERR;
                end
            end
            S_CNT0: begin
                if (rx_valid_i)       state_d = S_CNT1;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_CNT1: begin
                if (rx_valid_i) begin
                    if ({rx_data_i, cnt_lo_q} == 16'd0) begin
`ifdef UPG_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    if (byte_idx_q == 2'd3 && last_word) begin
`ifdef UPG_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_FIN;
`endif
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
`ifdef UPG_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid_i)       state_d = (rx_data_i == chk_q) ? S_DONE : S_ERR;
                else if (timeout_hit) state_d = S_ERR;
            end
`else
            S_FIN:   state_d = S_DONE;
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            upg_tgt_o  <= 1'b0;
            upg_wen_o  <= 1'b0;
            upg_addr_o <= '0;
            upg_data_o <= '0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            cnt_lo_q   <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            to_cnt_q   <= '0;
`ifdef UPG_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            upg_wen_o  <= 1'b0;
            // DONE and ERR have no exits, so these flags stay set until reset.
            upg_done_o <= (state_d == S_DONE);
            upg_err_o  <= (state_d == S_ERR);

            if (rx_valid_i || !counting) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (rx_valid_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data_i[7:1] == 7'd0) upg_tgt_o <= rx_data_i[0];
                    end
                    S_CNT0: begin
                        cnt_lo_q <= rx_data_i;
`ifdef UPG_CHECKSUM_EN
                        chk_q    <= rx_data_i;
`endif
                    end
                    S_CNT1: begin
                        word_cnt_q <= {rx_data_i, cnt_lo_q};
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
`ifdef UPG_CHECKSUM_EN
                        chk_q      <= chk_q ^ rx_data_i;
`endif
                    end
                    S_DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef UPG_CHECKSUM_EN
                        chk_q      <= chk_q ^ rx_data_i;
`endif
                        case (byte_idx_q)
                            2'd0: word_buf_q[7:0]   <= rx_data_i;
                            2'd1: word_buf_q[15:8]  <= rx_data_i;
                            2'd2: word_buf_q[23:16] <= rx_data_i;
                            default: begin
                                word_idx_q <= word_idx_q + 16'd1;
                                if (in_range) begin
                                    upg_wen_o  <= 1'b1;
                                    upg_addr_o <= word_idx_q[ADDR_W-1:0];
                                    upg_data_o <= {rx_data_i, word_buf_q};
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
